uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 75 +++++++
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Purpose  : Shared UART definitions: FSM state encoding, frame length |
// |            and the clock-to-baud divisor helper (also for uart_rx).  |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t c_st_idle  = 2'd0;
   localparam uart_state_t c_st_start = 2'd1;
   localparam uart_state_t c_st_data  = 2'd2;
   localparam uart_state_t c_st_stop  = 2'd3;

   // start + 8 data + stop
   localparam int FRAME_BITS = 10;

   // Bit period in clock cycles, integer truncation.
   function automatic int divisor(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_if                                                |
// | Purpose  : Byte valid/ready handshake between the core and uart_tx.  |
// | Ports    : tx_data  - byte to send                                   |
// |            tx_valid - tx_data is presented                           |
// |            tx_ready - transmitter can accept a byte                  |
// |            master   - byte producer, slave - uart_tx                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                              |
// | Purpose  : Small synchronous FIFO buffering bytes ahead of the       |
// |            serialiser. Read data is show-ahead (head entry visible   |
// |            combinationally).                                         |
// | Ports    : clk, resetn (async, active-low)                           |
// |            push/wdata - write side, ignored when full                |
// |            pop/rdata  - read side, ignored when empty                |
// |            full, empty, count - occupancy status                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  wire                      clk,
   input  wire                      resetn,
   input  wire                      push,
   input  wire  [WIDTH-1:0]         wdata,
   input  wire                      pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;

   logic w_do_push;
   logic w_do_pop;

   assign full      = (r_count == c_cw'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx                                                   |
// | Purpose  : 8N1 UART transmitter with a byte FIFO in front. Frames    |
// |            are sent LSB first, back-to-back when data is queued.     |
// | Ports    : clk, resetn (async, active-low)                           |
// |            s_tx   - valid/ready byte input (uart_tx_if.slave)        |
// |            busy   - FIFO non-empty or frame in progress              |
// |            tx     - serial line, idle high, registered               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  wire          clk,
   input  wire          resetn,
   uart_tx_if.slave     s_tx,
   output logic         busy,
   output logic         tx
);

   localparam int DIVISOR  = divisor(CLK_FREQ_HZ, BAUD);
   localparam int c_cnt_w  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int c_fcnt_w = $clog2(FIFO_DEPTH) + 1;

   localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(DIVISOR - 1);
   localparam logic [2:0]         c_last_bit   = 3'(FRAME_BITS - 3);

   generate
      if (DIVISOR < 2) begin : g_bad_divisor
         $error("uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   uart_state_t          r_state;
   uart_state_t          w_state_next;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2:0]           r_bit_idx;
   logic [7:0]           r_shift;
   logic                 r_tx;
   logic                 w_tx_next;
   logic                 w_pop;
   logic                 w_boundary;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [7:0]           w_fifo_rdata;
   logic [c_fcnt_w-1:0]  w_fifo_count;

   // Ready reflects the pre-pop occupancy, so a push on the cycle a full
   // FIFO pops is refused and retried on the following edge.
   assign s_tx.tx_ready = !w_fifo_full;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (s_tx.tx_valid && !w_fifo_full),
      .wdata  (s_tx.tx_data),
      .pop    (w_pop),
      .rdata  (w_fifo_rdata),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty),
      .count  (w_fifo_count)
   );

   assign w_boundary = (r_cnt == '0);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle:  if (!w_fifo_empty) w_state_next = c_st_start;
         c_st_start: if (w_boundary)    w_state_next = c_st_data;
         c_st_data:  if (w_boundary && (r_bit_idx == c_last_bit)) w_state_next = c_st_stop;
         c_st_stop:  if (w_boundary)    w_state_next = w_fifo_empty ? c_st_idle : c_st_start;
         default:                       w_state_next = c_st_idle;
      endcase
   end

   // ---------------- output logic ----------------
   // w_tx_next is the level for the current state; it is registered, so the
   // line lags the state by one cycle while every bit still lasts DIVISOR.
   always_comb begin
      w_tx_next = 1'b1;
      w_pop     = 1'b0;
      case (r_state)
         c_st_idle: begin
            w_pop = !w_fifo_empty;
         end
         c_st_start: begin
            w_tx_next = 1'b0;
         end
         c_st_data: begin
            w_tx_next = r_shift[0];
         end
         c_st_stop: begin
            // Popping on the last stop cycle chains frames with no idle gap.
            w_pop = w_boundary && !w_fifo_empty;
         end
         default: begin
            w_tx_next = 1'b1;
         end
      endcase
   end

   // ---------------- datapath: baud counter, shifter, line ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_tx <= w_tx_next;

         // Idle holds the counter; a pop starts a fresh bit period.
         if (r_state == c_st_idle) begin
            if (w_pop) begin
               r_cnt <= c_cnt_reload;
            end
         end else if (w_boundary) begin
            r_cnt <= c_cnt_reload;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_pop) begin
            r_shift <= w_fifo_rdata;
         end else if ((r_state == c_st_data) && w_boundary) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end

         if (r_state == c_st_start) begin
            r_bit_idx <= '0;
         end else if ((r_state == c_st_data) && w_boundary) begin
            r_bit_idx <= r_bit_idx + 1'b1;
         end
      end
   end

   assign tx   = r_tx;
   assign busy = (w_fifo_count != '0) || (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                |
// | Purpose  : Directed self-checking bench for uart_tx. Instance u_dut1 |
// |            runs with DIVISOR=10, u_dut2 with DIVISOR=2. A line       |
// |            decoder on u_dut1.tx collects received frames.            |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_tx;

   logic clk = 1'b0;
   logic resetn;
   logic busy1, tx1, busy2, tx2;

   uart_tx_if if1();
   uart_tx_if if2();

   uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)) u_dut1 (
      .clk    (clk),
      .resetn (resetn),
      .s_tx   (if1),
      .busy   (busy1),
      .tx     (tx1)
   );

   uart_tx #(.CLK_FREQ_HZ(200), .BAUD(100), .FIFO_DEPTH(4)) u_dut2 (
      .clk    (clk),
      .resetn (resetn),
      .s_tx   (if2),
      .busy   (busy2),
      .tx     (tx2)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- line decoder for u_dut1 (10 cycles per bit) --------
   logic [9:0] rx_q[$];
   int         start_q[$];
   int         mon_k = -1;
   logic [9:0] mon_sh = '0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (resetn !== 1'b1) begin
            mon_k = -1;
         end else begin
            if (mon_k < 0) begin
               if (tx1 === 1'b0) begin
                  mon_k = 0;
                  start_q.push_back(cyc);
               end
            end else begin
               mon_k++;
            end
            // Mid-bit sampling; after 10 samples bit0=start, bit9=stop.
            if (mon_k >= 0 && (mon_k % 10) == 5) mon_sh = {tx1, mon_sh[9:1]};
            if (mon_k == 95) rx_q.push_back(mon_sh);
            if (mon_k == 99) mon_k = -1;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick(1);
   endtask

   // Presents b (valid left high) and returns the edge at which it was taken.
   task automatic push1(input logic [7:0] b, output int acc);
      if1.tx_data  = b;
      if1.tx_valid = 1'b1;
      for (int w = 0; w < 1000 && if1.tx_ready !== 1'b1; w++) tick(1);
      if (if1.tx_ready !== 1'b1) check("push1_timeout", 32'(if1.tx_ready), 32'd1);
      tick(1);
      acc = cyc;
   endtask

   task automatic push2(input logic [7:0] b, output int acc);
      if2.tx_data  = b;
      if2.tx_valid = 1'b1;
      for (int w = 0; w < 1000 && if2.tx_ready !== 1'b1; w++) tick(1);
      if (if2.tx_ready !== 1'b1) check("push2_timeout", 32'(if2.tx_ready), 32'd1);
      tick(1);
      acc = cyc;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         a, acc, lows, acc_n, guard;
      logic [9:0] f0, f1;
      logic [7:0] d;
      logic       v;
      logic [7:0] b2[5]  = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81};
      logic [7:0] b3[6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [7:0] exp_q[$];

      resetn       = 1'b0;
      if1.tx_valid = 1'b0;
      if1.tx_data  = '0;
      if2.tx_valid = 1'b0;
      if2.tx_data  = '0;
      tick(3);
      check("rst_tx1",    32'(tx1),          32'd1);
      check("rst_busy1",  32'(busy1),        32'd0);
      check("rst_ready1", 32'(if1.tx_ready), 32'd1);
      check("rst_tx2",    32'(tx2),          32'd1);
      check("rst_busy2",  32'(busy2),        32'd0);
      check("rst_ready2", 32'(if2.tx_ready), 32'd1);
      resetn = 1'b1;
      tick(2);

      // ---- single byte 0x55: start bit 2 cycles after accept ----
      rx_q.delete();
      start_q.delete();
      push1(8'h55, a);
      if1.tx_valid = 1'b0;
      check("t1_busy_accept", 32'(busy1), 32'd1);
      check("t1_tx_n0", 32'(tx1), 32'd1);
      tick(1);
      check("t1_tx_n1", 32'(tx1), 32'd1);
      tick(1);
      check("t1_tx_n2", 32'(tx1), 32'd0);
      f0 = {1'b1, 8'h55, 1'b0};
      wait_until(a + 11);
      check("t1_start_last", 32'(tx1), 32'd0);
      for (int j = 0; j < 10; j++) begin
         wait_until(a + 2 + 10*j + 5);
         check($sformatf("t1_slot%0d", j), 32'(tx1), 32'(f0[j]));
      end
      wait_until(a + 100);
      check("t1_busy_n100", 32'(busy1), 32'd1);
      tick(1);
      check("t1_busy_n101", 32'(busy1), 32'd0);
      tick(2);
      check("t1_rx_count", 32'(rx_q.size()), 32'd1);
      check("t1_rx_frame", 32'((rx_q.size() > 0) ? rx_q[0] : 10'h0), 32'(f0));

      // ---- five bytes with valid held high ----
      tick(5);
      rx_q.delete();
      start_q.delete();
      for (int i = 0; i < 5; i++) begin
         push1(b2[i], acc);
         if (i == 0) a = acc;
         check($sformatf("t2_accept%0d", i), 32'(acc - a), 32'(i));
      end
      if1.tx_valid = 1'b0;
      check("t2_ready_full", 32'(if1.tx_ready), 32'd0);
      wait_until(a + 100);
      check("t2_ready_before_pop", 32'(if1.tx_ready), 32'd0);
      tick(1);
      check("t2_ready_after_pop", 32'(if1.tx_ready), 32'd1);
      wait_until(a + 504);
      check("t2_busy_end", 32'(busy1), 32'd0);
      check("t2_rx_count", 32'(rx_q.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check($sformatf("t2_rx%0d", i), 32'(rx_q[i]), 32'({1'b1, b2[i], 1'b0}));
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_gap%0d", i), 32'(start_q[i+1] - start_q[i]), 32'd100);

      // ---- push on the exact cycle a full FIFO pops ----
      tick(5);
      rx_q.delete();
      start_q.delete();
      for (int i = 0; i < 5; i++) begin
         push1(b3[i], acc);
         if (i == 0) a = acc;
      end
      if1.tx_data  = b3[5];
      if1.tx_valid = 1'b1;
      wait_until(a + 100);
      check("t3_ready_before_pop", 32'(if1.tx_ready), 32'd0);
      tick(1);
      check("t3_ready_after_pop", 32'(if1.tx_ready), 32'd1);
      tick(1);
      if1.tx_valid = 1'b0;
      check("t3_ready_refull", 32'(if1.tx_ready), 32'd0);
      wait_until(a + 604);
      check("t3_busy_end", 32'(busy1), 32'd0);
      check("t3_rx_count", 32'(rx_q.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("t3_rx%0d", i), 32'(rx_q[i]), 32'({1'b1, b3[i], 1'b0}));

      // ---- reset during bit 3 with two bytes queued ----
      tick(5);
      rx_q.delete();
      start_q.delete();
      push1(8'h00, a);
      push1(8'h12, acc);
      push1(8'h34, acc);
      if1.tx_valid = 1'b0;
      wait_until(a + 45);
      check("t4_mid_bit3", 32'(tx1), 32'd0);
      check("t4_busy_pre", 32'(busy1), 32'd1);
      resetn = 1'b0;
      #1;
      check("t4_tx_async", 32'(tx1), 32'd1);
      check("t4_busy_async", 32'(busy1), 32'd0);
      check("t4_ready_async", 32'(if1.tx_ready), 32'd1);
      tick(3);
      resetn = 1'b1;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (tx1 !== 1'b1) lows++;
      end
      check("t4_no_frames", 32'(lows), 32'd0);
      check("t4_busy_after", 32'(busy1), 32'd0);
      check("t4_rx_count", 32'(rx_q.size()), 32'd0);

      // ---- 200 random bytes with toggling valid ----
      rx_q.delete();
      start_q.delete();
      exp_q.delete();
      acc_n = 0;
      guard = 0;
      while (acc_n < 200 && guard < 60000) begin
         d = 8'($urandom);
         v = 1'($urandom_range(0, 1));
         if1.tx_data  = d;
         if1.tx_valid = v;
         if (v && if1.tx_ready === 1'b1) begin
            exp_q.push_back(d);
            acc_n++;
         end
         tick(1);
         guard++;
      end
      if1.tx_valid = 1'b0;
      check("t5_accepted", 32'(acc_n), 32'd200);
      for (int w = 0; w < 2000 && busy1 !== 1'b0; w++) tick(1);
      check("t5_busy_end", 32'(busy1), 32'd0);
      tick(5);
      check("t5_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("t5_rx%0d", i), 32'(rx_q[i]), 32'({1'b1, exp_q[i], 1'b0}));

      // ---- DIVISOR=2: two back-to-back 20-cycle frames ----
      push2(8'hB4, a);
      push2(8'h4B, acc);
      if2.tx_valid = 1'b0;
      check("t6_accept2", 32'(acc - a), 32'd1);
      check("t6_tx_pre", 32'(tx2), 32'd1);
      f0 = {1'b1, 8'hB4, 1'b0};
      f1 = {1'b1, 8'h4B, 1'b0};
      for (int k = 0; k < 40; k++) begin
         wait_until(a + 2 + k);
         check($sformatf("t6_bit%0d", k), 32'(tx2),
               32'((k < 20) ? f0[k/2] : f1[(k-20)/2]));
         if (k == 38) check("t6_busy_last", 32'(busy2), 32'd1);
         if (k == 39) check("t6_busy_drop", 32'(busy2), 32'd0);
      end
      tick(1);
      check("t6_tx_idle", 32'(tx2), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
